// File: rtl/pc_unit.sv
// Fetch-stage program counter: BOOT/RUN/HALT control, trap/redirect priority, epoch tagging.
// Optional macro PC_ALIGN_CHECK_EN turns misaligned redirects into traps and adds misalign_err.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int              INC       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_epoch,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            misalign_err
`endif
);

    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INC - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic            handshake;
    logic [XLEN-1:0] target_aligned;
`ifdef PC_ALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
    logic            target_misaligned;
    assign target_misaligned = |(redirect_target & ~ALIGN_MASK);
`endif

    assign handshake      = (state_q == RUN) && fetch_ready;
    assign target_aligned = redirect_target & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            epoch_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                // Control inputs are deliberately ignored during the boot bubble.
                state_d = RUN;
            end
            RUN: begin
                if (trap_req) begin
                    pc_d    = TRAP_VEC;
                    epoch_d = ~epoch_q;
                end else if (redirect_valid) begin
                    epoch_d = ~epoch_q;
`ifdef PC_ALIGN_CHECK_EN
                    if (target_misaligned) begin
                        pc_d       = TRAP_VEC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = target_aligned;
                    end
`else
                    pc_d = target_aligned;
`endif
                end else begin
                    // A fetch accepted in the halting cycle still advances pc.
                    if (handshake) begin
                        pc_d = pc_q + INC_V;
                    end
                    if (halt_req) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (trap_req) begin
                    pc_d    = TRAP_VEC;
                    epoch_d = ~epoch_q;
                    state_d = RUN;
                end else begin
                    if (redirect_valid) begin
                        epoch_d = ~epoch_q;
`ifdef PC_ALIGN_CHECK_EN
                        if (target_misaligned) begin
                            pc_d       = TRAP_VEC;
                            misalign_d = 1'b1;
                            state_d    = RUN;
                        end else begin
                            pc_d = target_aligned;
                        end
`else
                        pc_d = target_aligned;
`endif
                    end
                    if (resume && !halt_req) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign fetch_valid = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign fetch_pc    = pc_q;
    assign fetch_epoch = epoch_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err = misalign_q;
`endif

endmodule
